unit_input_pkt: RTL and testbench
=================================

UNIT_INPUT_PKT -- requirements
Module: unit_input_pkt

Interface
REQ-001 Parameter N_THREADS, default 16: threads served; thread index width TN = clog2(N_THREADS).
REQ-002 Parameter INPUT_WIDTH, default 8: input bus width; legal values 8, 16, 32; RATIO = 32/INPUT_WIDTH.
REQ-003 Parameter BUF_DEPTH, default 32: input buffer entries; power of 2, at least 8.
REQ-004 Parameter AFULL_SIZE, default 13: afull asserts when buffer occupancy >= BUF_DEPTH-AFULL_SIZE.
REQ-005 Parameter MEM_ADDR_WIDTH, default 5: per-thread memory word address width.
REQ-006 Parameter ENTRY_PT_WIDTH, default 2: entry point field width.
REQ-007 Parameter TS_WIDTH, default 2: thread state width; TS_NONE=0, TS_WR_RDY=1.
REQ-008 CLK  in  1  sole clock; all logic on rising edge.
REQ-009 RST  in  1  reset, asynchronous, active-high.
REQ-010 in  in  INPUT_WIDTH  input data or header.
REQ-011 wr_en  in  1  input word valid.
REQ-012 ctrl  in  1  marks header word (first) and last data word.
REQ-013 afull  out  1  input buffer almost full; source stops at most AFULL_SIZE-2 words later.
REQ-014 ready  out  1  block accepts a new data packet.
REQ-015 err  out  1  sticky protocol error; cleared by RST only.
REQ-016 out  out  32  packed memory word.
REQ-017 mem_addr  out  TN+MEM_ADDR_WIDTH  {thread_num, word address}.
REQ-018 rd_en  in  1  memory consumed out.
REQ-019 empty  out  1  out not valid.
REQ-020 ts_num  out  TN  current thread.
REQ-021 ts_wr_en  out  1  one-cycle thread state write strobe.
REQ-022 ts_wr  out  TS_WIDTH  constant TS_WR_RDY.
REQ-023 ts_rd  in  TS_WIDTH  thread state of ts_num, 2-cycle read latency.
REQ-024 entry_pt_curr  out  ENTRY_PT_WIDTH  current entry point.
REQ-025 pkt_words  out  MEM_ADDR_WIDTH+1  32-bit words written by last completed data packet.

Function
REQ-026 Header = word with wr_en&ctrl in state IDLE; in[2:0] is type; type 0 data (only while ready=1), type 1 entry point, others unknown.
REQ-027 Type 1: entry_pt_curr <= in[ENTRY_PT_WIDTH+2:3] (INPUT_WIDTH=8 limits ENTRY_PT_WIDTH to 5); state SKIP until next wr_en&ctrl word, then IDLE.
REQ-028 Unknown type, or type 0 with ready=0: set err, state SKIP.
REQ-029 Input FSM: IDLE -> GOING (type 0) -> DRAIN (last word written) -> MARK -> SEARCH1 -> SEARCH2 -> SEARCH3 -> IDLE or SEARCH1.
REQ-030 GOING: every wr_en word written to circular buffer, pointers wrap mod BUF_DEPTH; ready=0 from GOING entry until IDLE return.
REQ-031 Write while buffer full: word dropped, err set.
REQ-032 Packing: first sub-word to out[INPUT_WIDTH-1:0], ascending; empty falls the cycle after the RATIO-th sub-word is read.
REQ-033 Buffer reads pause while empty=0; rd_en with empty=0 raises empty and increments word address next cycle; simultaneous rd_en and refill: consume first, refill next cycle.
REQ-034 Word address resets to 0 at each data packet start; words beyond 2^MEM_ADDR_WIDTH dropped, err set.
REQ-035 Packet end with partial word: remaining sub-words zero, word presented, err set.
REQ-036 DRAIN exits when buffer empty, empty=1; pkt_words updated; MARK pulses ts_wr_en for ts_num.
REQ-037 SEARCH1: thread_num <= (thread_num+1) mod N_THREADS; SEARCH3: ts_rd==TS_NONE -> ready=1, IDLE; else SEARCH1; search is unbounded.
REQ-038 afull updated every cycle from occupancy, independent of state.
REQ-039 Single-cycle wr_en&ctrl data word while GOING ends the packet (one data word legal).

Reset
REQ-040 RST asserted at any time, including mid-packet or mid-search: immediately afull=0, ready=1, err=0, empty=1, out=0, ts_wr_en=0, thread_num=0, word address=0, pointers=0, entry_pt_curr=0, pkt_words=0, FSMs IDLE; partial packet discarded.

Verification
REQ-041 INPUT_WIDTH=8: header 0x00, data 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 (last ctrl) -> out 0x44332211 at addr {0,0}, 0x88776655 at {0,1}, pkt_words=2, one ts_wr_en for thread 0, ready=1 after ts_rd=0 for thread 1.
REQ-042 Header 0x09 then word with ctrl -> entry_pt_curr=1, no memory write, ready stays 1.
REQ-043 rd_en held low, 30 bytes streamed, BUF_DEPTH=32 -> afull=1 at occupancy 19; no drop, err=0.
REQ-044 Data packet of 6 bytes, INPUT_WIDTH=8 -> second word 0x0000_6655-style zero padding, err=1.
REQ-045 ts_rd nonzero for threads 1-3, zero for 4 -> ready=1 with ts_num=4 after 4 search loops.
REQ-046 RST pulsed mid-GOING -> all outputs at reset values same cycle; next packet lands at thread 0 address 0.

Source files
------------

// File: rtl/unit_input_pkt.sv
// Input packet unit: parses headers, buffers data sub-words, packs them into 32-bit memory
// words per thread, then searches for the next free thread before accepting another packet.
module unit_input_pkt #(
    parameter int N_THREADS      = 16,
    parameter int INPUT_WIDTH    = 8,
    parameter int BUF_DEPTH      = 32,
    parameter int AFULL_SIZE     = 13,
    parameter int MEM_ADDR_WIDTH = 5,
    parameter int ENTRY_PT_WIDTH = 2,
    parameter int TS_WIDTH       = 2,
    localparam int TN            = $clog2(N_THREADS)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [INPUT_WIDTH-1:0]        in,
    input  logic                          wr_en,
    input  logic                          ctrl,
    output logic                          afull,
    output logic                          ready,
    output logic                          err,
    output logic [31:0]                   out,
    output logic [TN+MEM_ADDR_WIDTH-1:0]  mem_addr,
    input  logic                          rd_en,
    output logic                          empty,
    output logic [TN-1:0]                 ts_num,
    output logic                          ts_wr_en,
    output logic [TS_WIDTH-1:0]           ts_wr,
    input  logic [TS_WIDTH-1:0]           ts_rd,
    output logic [ENTRY_PT_WIDTH-1:0]     entry_pt_curr,
    output logic [MEM_ADDR_WIDTH:0]       pkt_words
);
    localparam int RATIO = 32 / INPUT_WIDTH;
    localparam int AW    = $clog2(BUF_DEPTH);
    localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [SW-1:0]       SUB_LAST  = SW'(RATIO - 1);
    localparam logic [AW:0]         CNT_FULL  = (AW+1)'(BUF_DEPTH);
    localparam logic [AW:0]         AFULL_THR = (AW+1)'(BUF_DEPTH - AFULL_SIZE);
    localparam logic [TS_WIDTH-1:0] TS_NONE   = '0;
    localparam logic [TS_WIDTH-1:0] TS_WR_RDY = TS_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SKIP, S_GOING, S_DRAIN, S_MARK, S_SEARCH1, S_SEARCH2, S_SEARCH3
    } state_t;

    state_t                      state_q, state_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]                 count_q, count_d;
    logic                        afull_q, afull_d, ready_q, ready_d, err_q, err_d;
    logic                        empty_q, empty_d;
    logic [31:0]                 out_q, out_d;
    logic [SW-1:0]               sub_q, sub_d;
    logic [MEM_ADDR_WIDTH:0]     word_q, word_d, pkt_words_q, pkt_words_d;
    logic [TN-1:0]               thread_q, thread_d;
    logic [ENTRY_PT_WIDTH-1:0]   entry_q, entry_d;

    logic [INPUT_WIDTH:0]        buf_mem [BUF_DEPTH];
    logic [INPUT_WIDTH:0]        rd_data;
    logic                        wr_ok, pop, done;

    assign rd_data = buf_mem[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (wr_ok) buf_mem[wr_ptr_q] <= {ctrl, in};
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ready_d     = ready_q;
        err_d       = err_q;
        empty_d     = empty_q;
        out_d       = out_q;
        sub_d       = sub_q;
        word_d      = word_q;
        pkt_words_d = pkt_words_q;
        thread_d    = thread_q;
        entry_d     = entry_q;
        wr_ok       = 1'b0;
        done        = 1'b0;

        // Packer: consume the presented word first, refill only while out is empty.
        pop = empty_q && (count_q != '0);
        if (!empty_q && rd_en) begin
            empty_d = 1'b1;
            word_d  = word_q + (MEM_ADDR_WIDTH+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (sub_q == '0) out_d = 32'(rd_data[INPUT_WIDTH-1:0]);
            else out_d[sub_q*INPUT_WIDTH +: INPUT_WIDTH] = rd_data[INPUT_WIDTH-1:0];
            done = (sub_q == SUB_LAST) || rd_data[INPUT_WIDTH];
            if (done) begin
                sub_d = '0;
                if (word_q[MEM_ADDR_WIDTH]) err_d = 1'b1;
                else empty_d = 1'b0;
                if (sub_q != SUB_LAST) err_d = 1'b1;
            end else begin
                sub_d = sub_q + SW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (wr_en && ctrl) begin
                    state_d = S_SKIP;
                    if (in[2:0] == 3'd0 && ready_q) begin
                        state_d = S_GOING;
                        ready_d = 1'b0;
                        word_d  = '0;
                    end else if (in[2:0] == 3'd1) begin
                        entry_d = in[ENTRY_PT_WIDTH+2:3];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SKIP: if (wr_en && ctrl) state_d = S_IDLE;
            S_GOING: begin
                if (wr_en) begin
                    if (count_q == CNT_FULL) err_d = 1'b1;
                    else begin
                        wr_ok    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                    if (ctrl) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count_q == '0 && empty_q) begin
                    state_d     = S_MARK;
                    pkt_words_d = word_q;
                    sub_d       = '0;
                end
            end
            S_MARK: state_d = S_SEARCH1;
            S_SEARCH1: begin
                thread_d = (thread_q == TN'(N_THREADS - 1)) ? '0 : thread_q + TN'(1);
                state_d  = S_SEARCH2;
            end
            S_SEARCH2: state_d = S_SEARCH3;
            S_SEARCH3: begin
                if (ts_rd == TS_NONE) begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SEARCH1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(pop);
        afull_d = (count_d >= AFULL_THR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            afull_q     <= 1'b0;
            ready_q     <= 1'b1;
            err_q       <= 1'b0;
            empty_q     <= 1'b1;
            out_q       <= '0;
            sub_q       <= '0;
            word_q      <= '0;
            pkt_words_q <= '0;
            thread_q    <= '0;
            entry_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            afull_q     <= afull_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            empty_q     <= empty_d;
            out_q       <= out_d;
            sub_q       <= sub_d;
            word_q      <= word_d;
            pkt_words_q <= pkt_words_d;
            thread_q    <= thread_d;
            entry_q     <= entry_d;
        end
    end

    assign afull         = afull_q;
    assign ready         = ready_q;
    assign err           = err_q;
    assign out           = out_q;
    assign empty         = empty_q;
    assign mem_addr      = {thread_q, word_q[MEM_ADDR_WIDTH-1:0]};
    assign ts_num        = thread_q;
    assign ts_wr_en      = (state_q == S_MARK);
    assign ts_wr         = TS_WR_RDY;
    assign entry_pt_curr = entry_q;
    assign pkt_words     = pkt_words_q;
endmodule

// File: tb/tb_unit_input_pkt.sv
// Directed bench for unit_input_pkt at default parameters (8-bit input, 16 threads, 32-entry buffer).
module tb_unit_input_pkt;
    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  in_w;
    logic        wr_en, ctrl, rd_en;
    logic        afull, ready, err, empty, ts_wr_en;
    logic [31:0] out_w;
    logic [8:0]  mem_addr;
    logic [3:0]  ts_num;
    logic [1:0]  ts_wr, ts_rd, entry_pt_curr;
    logic [5:0]  pkt_words;
    logic [15:0] busy_mask;

    int checks = 0;
    int errors = 0;
    int ts_wr_seen = 0;
    logic [3:0] ts_wr_thread;

    unit_input_pkt dut (
        .CLK(CLK), .RST(RST), .in(in_w), .wr_en(wr_en), .ctrl(ctrl),
        .afull(afull), .ready(ready), .err(err), .out(out_w), .mem_addr(mem_addr),
        .rd_en(rd_en), .empty(empty), .ts_num(ts_num), .ts_wr_en(ts_wr_en),
        .ts_wr(ts_wr), .ts_rd(ts_rd), .entry_pt_curr(entry_pt_curr), .pkt_words(pkt_words)
    );

    always #5 CLK = ~CLK;

    // thread state memory: registered read of the busy mask
    always @(posedge CLK) ts_rd <= busy_mask[ts_num] ? 2'd2 : 2'd0;

    always @(negedge CLK) begin
        if (ts_wr_en === 1'b1) begin
            ts_wr_seen = ts_wr_seen + 1;
            ts_wr_thread = ts_num;
        end
    end

    task automatic send(input logic [7:0] d, input logic c);
        in_w = d; wr_en = 1'b1; ctrl = c;
        @(negedge CLK);
        wr_en = 1'b0; ctrl = 1'b0;
    endtask

    task automatic consume();
        rd_en = 1'b1;
        @(negedge CLK);
        rd_en = 1'b0;
    endtask

    task automatic wait_word(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (empty === 1'b0) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge CLK);
        end
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        @(negedge CLK); @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({afull, ready, err, empty, ts_wr_en} !== 5'b01010) begin
            errors++; $display("FAIL reset_flags got %b exp 01010", {afull, ready, err, empty, ts_wr_en});
        end
        checks++;
        if ({out_w, mem_addr, ts_num, entry_pt_curr, pkt_words} !== '0) begin
            errors++; $display("FAIL reset_values out=%h addr=%h ts=%0d ep=%0d pw=%0d exp all 0",
                               out_w, mem_addr, ts_num, entry_pt_curr, pkt_words);
        end
        checks++;
        if (ts_wr !== 2'd1) begin errors++; $display("FAIL ts_wr got %0d exp 1", ts_wr); end
    endtask

    task automatic test_data_pkt();
        bit ok;
        int base;
        logic [7:0] bytes [8];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        base = ts_wr_seen;
        send(8'h00, 1'b1);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL data_ready_low got %b exp 0", ready); end
        for (int i = 0; i < 8; i++) send(bytes[i], i == 7);
        wait_word(ok);
        checks++;
        if (!ok || out_w !== 32'h44332211 || mem_addr !== 9'h000) begin
            errors++; $display("FAIL data_w0 out=%h addr=%h exp 44332211 000", out_w, mem_addr);
        end
        consume();
        wait_word(ok);
        checks++;
        if (!ok || out_w !== 32'h88776655 || mem_addr !== 9'h001) begin
            errors++; $display("FAIL data_w1 out=%h addr=%h exp 88776655 001", out_w, mem_addr);
        end
        consume();
        wait_ready(ok);
        checks++;
        if (!ok || ts_num !== 4'd1) begin
            errors++; $display("FAIL data_search ready=%b ts_num=%0d exp 1 1", ready, ts_num);
        end
        checks++;
        if (pkt_words !== 6'd2 || (ts_wr_seen - base) != 1 || ts_wr_thread !== 4'd0 || err !== 1'b0) begin
            errors++; $display("FAIL data_done pw=%0d strobes=%0d thr=%0d err=%b exp 2 1 0 0",
                               pkt_words, ts_wr_seen - base, ts_wr_thread, err);
        end
    endtask

    task automatic test_entry_pt();
        send(8'h09, 1'b1);
        send(8'h11, 1'b1);
        @(negedge CLK);
        checks++;
        if (entry_pt_curr !== 2'd1) begin
            errors++; $display("FAIL entry_pt got %0d exp 1", entry_pt_curr);
        end
        checks++;
        if ({ready, empty, err} !== 3'b110) begin
            errors++; $display("FAIL entry_side got %b exp 110", {ready, empty, err});
        end
    endtask

    task automatic test_partial();
        bit ok;
        send(8'h00, 1'b1);
        for (int i = 1; i <= 6; i++) send(8'(i * 8'h11), i == 6);
        wait_word(ok);
        checks++;
        if (!ok || out_w !== 32'h44332211 || mem_addr !== 9'h020) begin
            errors++; $display("FAIL part_w0 out=%h addr=%h exp 44332211 020", out_w, mem_addr);
        end
        consume();
        wait_word(ok);
        checks++;
        if (!ok || out_w !== 32'h00006655 || mem_addr !== 9'h021 || err !== 1'b1) begin
            errors++; $display("FAIL part_w1 out=%h addr=%h err=%b exp 00006655 021 1", out_w, mem_addr, err);
        end
        consume();
        wait_ready(ok);
        checks++;
        if (!ok || ts_num !== 4'd2 || pkt_words !== 6'd2) begin
            errors++; $display("FAIL part_done ts=%0d pw=%0d exp 2 2", ts_num, pkt_words);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send(8'h00, 1'b1);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        RST = 1'b1;
        #1;
        checks++;
        if ({afull, ready, err, empty, ts_wr_en} !== 5'b01010) begin
            errors++; $display("FAIL mid_rst_flags got %b exp 01010", {afull, ready, err, empty, ts_wr_en});
        end
        checks++;
        if ({out_w, mem_addr, ts_num, entry_pt_curr, pkt_words} !== '0) begin
            errors++; $display("FAIL mid_rst_values out=%h addr=%h ts=%0d ep=%0d pw=%0d exp all 0",
                               out_w, mem_addr, ts_num, entry_pt_curr, pkt_words);
        end
        @(negedge CLK);
        RST = 1'b0;
        send(8'h00, 1'b1);
        send(8'hA1, 1'b0); send(8'hB2, 1'b0); send(8'hC3, 1'b0); send(8'hD4, 1'b1);
        wait_word(ok);
        checks++;
        if (!ok || out_w !== 32'hD4C3B2A1 || mem_addr !== 9'h000) begin
            errors++; $display("FAIL mid_rst_pkt out=%h addr=%h exp d4c3b2a1 000", out_w, mem_addr);
        end
        consume();
        wait_ready(ok);
        checks++;
        if (!ok || ts_num !== 4'd1 || pkt_words !== 6'd1) begin
            errors++; $display("FAIL mid_rst_done ts=%0d pw=%0d exp 1 1", ts_num, pkt_words);
        end
    endtask

    task automatic test_unknown();
        send(8'h05, 1'b1);
        checks++;
        if (err !== 1'b1 || ready !== 1'b1) begin
            errors++; $display("FAIL unknown_type err=%b ready=%b exp 1 1", err, ready);
        end
        send(8'h02, 1'b1);
    endtask

    task automatic test_search();
        bit ok;
        int cyc;
        pulse_reset();
        busy_mask = 16'h000E;
        send(8'h00, 1'b1);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
        wait_word(ok);
        checks++;
        if (!ok || out_w !== 32'h04030201) begin
            errors++; $display("FAIL search_pkt out=%h exp 04030201", out_w);
        end
        consume();
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (ts_wr_en === 1'b1) begin ok = 1'b1; break; end
        end
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            cyc++;
            if (ready === 1'b1) break;
        end
        checks++;
        if (!ok || ready !== 1'b1 || ts_num !== 4'd4 || cyc != 13) begin
            errors++; $display("FAIL search_loops strobe=%b ready=%b ts=%0d cyc=%0d exp 1 1 4 13",
                               ok, ready, ts_num, cyc);
        end
        busy_mask = '0;
    endtask

    task automatic test_afull();
        pulse_reset();
        send(8'h00, 1'b1);
        for (int i = 1; i <= 22; i++) send(8'(i), 1'b0);
        checks++;
        if (afull !== 1'b0) begin errors++; $display("FAIL afull_below got %b exp 0", afull); end
        send(8'd23, 1'b0);
        checks++;
        if (afull !== 1'b1) begin errors++; $display("FAIL afull_at19 got %b exp 1", afull); end
        for (int i = 24; i <= 30; i++) send(8'(i), 1'b0);
        checks++;
        if ({afull, err, empty} !== 3'b100 || out_w !== 32'h04030201) begin
            errors++; $display("FAIL afull_30 flags=%b out=%h exp 100 04030201", {afull, err, empty}, out_w);
        end
        pulse_reset();
    endtask

    initial begin
        RST = 1'b1; in_w = '0; wr_en = 1'b0; ctrl = 1'b0; rd_en = 1'b0; busy_mask = '0;
        @(negedge CLK);
        test_reset();
        test_data_pkt();
        test_entry_pt();
        test_partial();
        test_reset_mid();
        test_unknown();
        test_search();
        test_afull();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
